imem_loader: RTL and testbench
==============================

# imem_loader

Programs the 64-word instruction memory from a byte stream so a new program can run without re-synthesising the memory init file. The block accepts bytes over a valid/ready handshake, assembles them little-endian into 32-bit words, and writes each word through the instruction memory's write port at word-aligned byte addresses. It holds the processor in reset from power-up until a load completes.

## Interface
- WORDS, 64: instruction memory depth in words. Must be a power of two.
- LW, $clog2(WORDS)+1: width of the word-count input; it must be able to hold the value WORDS.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse that begins a load; sampled only in IDLE.
- load_words  in  LW  number of words to load; legal range is 1..WORDS; latched when start is accepted.
- rx_valid  in  1  a byte is present on rx_data.
- rx_data  in  8  byte payload.
- rx_ready  out  1  loader accepts a byte this cycle.
- we  out  1  memory write enable; one-cycle pulse per word.
- wa  out  32  byte address of the write, always word-aligned ({word_idx, 2'b00}, zero-extended).
- wd  out  32  assembled word.
- busy  out  1  high in RECV and WRITE.
- done  out  1  one-cycle pulse when the last word has been written.
- err  out  1  one-cycle pulse when start is issued with an illegal load_words.
- cpu_reset  out  1  holds the processor in reset.

## Operation
- The FSM has four states: IDLE, RECV, WRITE and DONE. It resets to IDLE.
- **IDLE**
  - rx_ready=0, we=0, busy=0.
  - If start=1 and load_words is in 1..WORDS: latch load_words, clear word_idx and byte_idx, set cpu_reset=1, go to RECV.
  - If start=1 and load_words is 0 or greater than WORDS: pulse err=1 for one cycle and stay in IDLE. cpu_reset is unchanged.
- **RECV**
  - rx_ready=1.
  - On each handshake (rx_valid & rx_ready), write rx_data into byte lane byte_idx of the word register. The first byte lands in [7:0] and the fourth in [31:24]. Then increment byte_idx.
  - On the handshake with byte_idx==3, go to WRITE and wrap byte_idx to 0.
  - If rx_valid stays low, the state and the partial word hold indefinitely. There is no timeout.
- **WRITE**
  - rx_ready=0, we=1, wa={word_idx,2'b00}, wd=word register.
  - If word_idx==latched_len-1, go to DONE. Otherwise increment word_idx and go to RECV.
- **DONE**
  - done=1 and cpu_reset=0, then go to IDLE.
- **cpu_reset**
  - Reset value is 1. It stays 1 until the first successful load reaches DONE.
  - After that it stays 0 in IDLE until the next accepted start.
  - An err does not change it.
- start outside IDLE is ignored.
- Reset asserted mid-load: all state and outputs return to their reset values and the partial word is discarded. Words already written stay in the memory; the loader never clears the memory.
- wa bits [1:0] are always 0. Bits above index $clog2(WORDS)+1 are always 0.

## Timing
- Reset values: rx_ready=0, we=0, wa=0, wd=0, busy=0, done=0, err=0, cpu_reset=1.
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- With start accepted at edge 0 and rx_valid held high:
  - bytes are accepted on cycles 1–4;
  - the first we pulse is in cycle 5;
  - each word takes 4 handshake cycles plus 1 WRITE cycle;
  - the last we pulse is in cycle 5N;
  - done=1 and cpu_reset=0 are in cycle 5N+1;
  - IDLE is re-entered in cycle 5N+2.
- A byte stall adds exactly one cycle per idle rx_valid cycle.
- The memory write port captures wd/wa on the rising edge that ends the we cycle.
- err is asserted in the cycle after the illegal start is sampled.

## Test plan
- **Power-up:** release reset → cpu_reset=1, rx_ready=0, all other outputs 0.
- **Single-word load:** start with load_words=1, then bytes 0x13,0x05,0x50,0x00 back-to-back → exactly one we, with wa=0x0000_0000 and wd=0x0050_0513 in cycle 5; done and cpu_reset=0 in cycle 6.
- **Full 64-word load with random rx_valid gaps:**
  - each word k must be written once, with wa=4k and the correct little-endian data;
  - the reference model of the memory must match;
  - done follows the write at wa=0xFC by one cycle.
- **Illegal length:**
  - start with load_words=0 → err pulse, FSM stays IDLE, cpu_reset unchanged, no we;
  - repeat with load_words=65 → same result.
- **Reset mid-load:** assert reset after the 2nd byte of word 3 → outputs return to reset values, no further we; words 0–2 remain in memory. A new load then starts from wa=0.
- **start while busy:** pulse start with a different load_words during RECV → ignored; the original length completes.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: assembles little-endian words,
// writes them at word-aligned byte addresses and holds the CPU in reset until a load completes.
module imem_loader #(
  parameter int unsigned WORDS = 64,
  parameter int unsigned LW    = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [LW-1:0] load_words,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          we,
  output logic [31:0]   wa,
  output logic [31:0]   wd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_reset
);

  localparam int unsigned IW = $clog2(WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state, state_d;
  logic [IW-1:0] word_idx, word_idx_d;
  logic [1:0]    byte_idx, byte_idx_d;
  logic [LW-1:0] len, len_d;
  logic [31:0]   word, word_d;
  logic [31:0]   wa_d, wd_d;
  logic          rx_ready_d, we_d, busy_d, done_d, err_d, cpu_reset_d;
  logic          len_ok, last_word;

  assign len_ok    = (load_words != '0) && (load_words <= LW'(WORDS));
  assign last_word = (LW'(word_idx) == (len - LW'(1)));

  // Next-state and next-output decode; outputs are registered from the next state.
  always_comb begin
    state_d     = state;
    word_idx_d  = word_idx;
    byte_idx_d  = byte_idx;
    len_d       = len;
    word_d      = word;
    wa_d        = wa;
    wd_d        = wd;
    err_d       = 1'b0;
    cpu_reset_d = cpu_reset;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d       = load_words;
            word_idx_d  = '0;
            byte_idx_d  = '0;
            cpu_reset_d = 1'b1;
            state_d     = S_RECV;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (rx_valid && rx_ready) begin
          word_d[{byte_idx, 3'b000} +: 8] = rx_data;
          byte_idx_d = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            state_d = S_WRITE;
            wa_d    = 32'({word_idx, 2'b00});
            wd_d    = {rx_data, word[23:0]};
          end
        end
      end
      S_WRITE: begin
        if (last_word) begin
          state_d     = S_DONE;
          cpu_reset_d = 1'b0;
        end else begin
          word_idx_d = word_idx + IW'(1);
          state_d    = S_RECV;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rx_ready_d = (state_d == S_RECV);
    we_d       = (state_d == S_WRITE);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      byte_idx  <= '0;
      len       <= '0;
      word      <= '0;
      wa        <= '0;
      wd        <= '0;
      rx_ready  <= 1'b0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      state     <= state_d;
      word_idx  <= word_idx_d;
      byte_idx  <= byte_idx_d;
      len       <= len_d;
      word      <= word_d;
      wa        <= wa_d;
      wd        <= wd_d;
      rx_ready  <= rx_ready_d;
      we        <= we_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      cpu_reset <= cpu_reset_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-count based reference model checked every cycle,
// plus literal expectations for power-up, single word, illegal length, full load and reset.
module tb_imem_loader;

  localparam int unsigned WORDS = 64;
  localparam int unsigned LW    = $clog2(WORDS) + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic [LW-1:0] load_words;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready, we, busy, done, err, cpu_reset;
  logic [31:0]   wa, wd;

  int checks;
  int errors;

  imem_loader #(.WORDS(WORDS), .LW(LW)) dut (
    .clk(clk), .reset(reset), .start(start), .load_words(load_words),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .we(we), .wa(wa), .wd(wd), .busy(busy), .done(done), .err(err),
    .cpu_reset(cpu_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory as the write port would see it, plus write counters.
  logic [31:0] dut_mem [WORDS];
  int          wcount  [WORDS];
  int          we_total;
  initial we_total = 0;
  always @(posedge clk) begin
    if (we) begin
      dut_mem[wa[7:2]] <= wd;
      wcount[wa[7:2]]  <= wcount[wa[7:2]] + 1;
      we_total         <= we_total + 1;
    end
  end

  // Reference model: counts accepted bytes; every 4th byte forms a word written next cycle.
  logic        m_collect, m_we, m_done, m_err, m_cpu;
  logic [31:0] m_wa, m_wd, m_word;
  int          m_nb, m_idx, m_len;
  logic [31:0] ref_mem [WORDS];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_collect <= 1'b0; m_we <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_cpu <= 1'b1;
      m_wa <= '0; m_wd <= '0; m_word <= '0; m_nb <= 0; m_idx <= 0; m_len <= 0;
    end else begin
      m_we <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
      if (!m_collect && !m_we && !m_done) begin
        if (start) begin
          if (int'(load_words) >= 1 && int'(load_words) <= WORDS) begin
            m_collect <= 1'b1; m_len <= int'(load_words); m_idx <= 0; m_nb <= 0; m_cpu <= 1'b1;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else if (m_collect && rx_valid) begin
        m_word <= (m_word & ~(32'hFF << (8 * m_nb))) | (32'(rx_data) << (8 * m_nb));
        if (m_nb == 3) begin
          m_collect      <= 1'b0;
          m_we           <= 1'b1;
          m_wa           <= 32'(4 * m_idx);
          m_wd           <= {rx_data, m_word[23:0]};
          ref_mem[m_idx] <= {rx_data, m_word[23:0]};
          m_nb           <= 0;
        end else begin
          m_nb <= m_nb + 1;
        end
      end else if (m_we) begin
        if (m_idx == m_len - 1) begin
          m_done <= 1'b1; m_cpu <= 1'b0;
        end else begin
          m_idx <= m_idx + 1; m_collect <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("m_we",        32'(we),        32'(m_we));
      chk("m_done",      32'(done),      32'(m_done));
      chk("m_err",       32'(err),       32'(m_err));
      chk("m_cpu_reset", 32'(cpu_reset), 32'(m_cpu));
      chk("m_rx_ready",  32'(rx_ready),  32'(m_collect));
      chk("m_busy",      32'(busy),      32'(m_collect | m_we));
      if (m_we) begin
        chk("m_wa", wa, m_wa);
        chk("m_wd", wd, m_wd);
      end
    end
  end

  function automatic logic [31:0] fw(input int k);
    logic [7:0] kb;
    kb = 8'(k);
    return {kb ^ 8'h5A, 8'(k * 3), kb + 8'h11, ~kb};
  endfunction

  task automatic do_start(input int n);
    start      = 1'b1;
    load_words = LW'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
    chk({tag, "_we"},        32'(we),        32'd0);
    chk({tag, "_wa"},        wa,             32'd0);
    chk({tag, "_wd"},        wd,             32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_err"},       32'(err),       32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
  endtask

  int base;

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; load_words = '0; rx_valid = 1'b0; rx_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("powerup");

    // Illegal length 0 from power-up: err next cycle, cpu_reset stays 1.
    do_start(0);
    chk("ill0_err", 32'(err), 32'd1);
    chk("ill0_busy", 32'(busy), 32'd0);
    chk("ill0_cpu_reset", 32'(cpu_reset), 32'd1);
    @(negedge clk);
    chk("ill0_err_clear", 32'(err), 32'd0);

    // Single word, back-to-back bytes.
    base = we_total;
    do_start(1);
    send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    chk("single_we", 32'(we), 32'd1);
    chk("single_wa", wa, 32'h0000_0000);
    chk("single_wd", wd, 32'h0050_0513);
    @(negedge clk);
    chk("single_done", 32'(done), 32'd1);
    chk("single_cpu_reset", 32'(cpu_reset), 32'd0);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_we_count", 32'(we_total - base), 32'd1);

    // Illegal length 65 after a load: err, cpu_reset stays 0, no write.
    base = we_total;
    do_start(65);
    chk("ill65_err", 32'(err), 32'd1);
    chk("ill65_cpu_reset", 32'(cpu_reset), 32'd0);
    repeat (3) @(negedge clk);
    chk("ill65_no_we", 32'(we_total - base), 32'd0);

    // Full load with random byte gaps.
    do_start(64);
    for (int k = 0; k < 64; k++) send_word(fw(k), 2);
    chk("full_last_we", 32'(we), 32'd1);
    chk("full_last_wa", wa, 32'h0000_00FC);
    @(negedge clk);
    chk("full_done", 32'(done), 32'd1);
    chk("full_cpu_reset", 32'(cpu_reset), 32'd0);
    for (int k = 0; k < 64; k++) begin
      chk($sformatf("full_mem%0d", k), dut_mem[k], fw(k));
      chk($sformatf("full_ref%0d", k), dut_mem[k], ref_mem[k]);
      chk($sformatf("full_cnt%0d", k), 32'(wcount[k]), (k == 0) ? 32'd2 : 32'd1);
    end
    @(negedge clk);

    // Start while busy is ignored; original length 2 completes.
    base = we_total;
    do_start(2);
    send_byte(8'h01, 0); send_byte(8'h02, 0);
    start = 1'b1; load_words = LW'(5);
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h03, 0); send_byte(8'h04, 0);
    chk("busy_wd0", wd, 32'h0403_0201);
    send_word(32'h8877_6655, 1);
    chk("busy_wa1", wa, 32'h0000_0004);
    wait_done();
    chk("busy_we_count", 32'(we_total - base), 32'd2);
    @(negedge clk);

    // Reset after the 2nd byte of word 3.
    do_start(5);
    send_word(32'h1122_3344, 0);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h0000_0093, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    base = we_total;
    #2 reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("after_reset");
    chk("rst_no_we", 32'(we_total - base), 32'd0);
    chk("rst_mem0", dut_mem[0], 32'h1122_3344);
    chk("rst_mem1", dut_mem[1], 32'hDEAD_BEEF);
    chk("rst_mem2", dut_mem[2], 32'h0000_0093);

    // A fresh load restarts at address 0.
    do_start(1);
    send_word(32'hCAFE_F00D, 0);
    chk("reload_we", 32'(we), 32'd1);
    chk("reload_wa", wa, 32'h0000_0000);
    chk("reload_wd", wd, 32'hCAFE_F00D);
    @(negedge clk);
    chk("reload_done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
